// File: rtl/imem_prog_encoder_pkg.sv
// Shared RV32I encode definitions: op_e, FSM states, opcodes, funct3/funct7.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Optional feature macro used by the encoder: LI_EXPAND_EN (LI pseudo-op expansion).
package imem_prog_encoder_pkg;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRA, OP_SRL, OP_OR, OP_AND,
    OP_ADDI, OP_SLLI, OP_SLTI, OP_SLTIU, OP_XORI, OP_SRAI, OP_SRLI, OP_ORI, OP_ANDI,
    OP_LW, OP_SW,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_JAL, OP_JALR, OP_LUI, OP_AUIPC,
    OP_LI
  } op_e;

  typedef enum logic [1:0] {S_RUN, S_LI2, S_FULL} state_e;

  // Major opcodes, named as on the decode side.
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;  // SUB / SRA / SRAI

  function automatic logic [2:0] funct3_of(op_e op);
    case (op)
      OP_SLL, OP_SLLI:                    return F3_SLL;
      OP_SLT, OP_SLTI:                    return F3_SLT;
      OP_SLTU, OP_SLTIU:                  return F3_SLTU;
      OP_XOR, OP_XORI:                    return F3_XOR;
      OP_SRA, OP_SRL, OP_SRAI, OP_SRLI:   return F3_SR;
      OP_OR, OP_ORI:                      return F3_OR;
      OP_AND, OP_ANDI:                    return F3_AND;
      OP_LW, OP_SW:                       return F3_W;
      OP_BNE:                             return F3_BNE;
      OP_BLT:                             return F3_BLT;
      OP_BGE:                             return F3_BGE;
      OP_BLTU:                            return F3_BLTU;
      OP_BGEU:                            return F3_BGEU;
      default:                            return F3_ADD;  // ADD/SUB/ADDI/BEQ/JALR/LI
    endcase
  endfunction

  function automatic logic [6:0] funct7_of(op_e op);
    return (op == OP_SUB || op == OP_SRA || op == OP_SRAI) ? F7_ALT : F7_BASE;
  endfunction

endpackage

// File: rtl/imem_prog_encoder_field_pack.sv
// rv32i_field_pack: combinational op + fields -> {32-bit word, legal}.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides whether to use the result.
// Ports: i_op/i_rd/i_rs1/i_rs2/i_imm in; o_word encoded instruction, o_legal immediate in range.
// OP_LI is packed as ADDI rd,x0,imm with legal = fits 12 bits; long-form LI is the top's job.
module rv32i_field_pack
  import imem_prog_encoder_pkg::*;
(
  input  op_e         i_op,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_legal
);

  logic       fits12, fits13, fits21, shamt_ok;
  logic [2:0] f3;
  logic [6:0] f7;

  // A value fits an N-bit signed field when all bits above N-1 copy the sign.
  assign fits12   = (i_imm[31:11] == '0) || (i_imm[31:11] == '1);
  assign fits13   = (i_imm[31:12] == '0) || (i_imm[31:12] == '1);
  assign fits21   = (i_imm[31:20] == '0) || (i_imm[31:20] == '1);
  assign shamt_ok = (i_imm[31:5] == '0);
  assign f3       = funct3_of(i_op);
  assign f7       = funct7_of(i_op);

  always_comb begin
    o_word  = '0;
    o_legal = 1'b0;
    case (i_op)
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRA, OP_SRL, OP_OR, OP_AND: begin
        o_word  = {f7, i_rs2, i_rs1, f3, i_rd, OPC_OP};
        o_legal = 1'b1;
      end
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI: begin
        o_word  = {i_imm[11:0], i_rs1, f3, i_rd, OPC_OP_IMM};
        o_legal = fits12;
      end
      OP_SLLI, OP_SRLI, OP_SRAI: begin
        o_word  = {f7, i_imm[4:0], i_rs1, f3, i_rd, OPC_OP_IMM};
        o_legal = shamt_ok;
      end
      OP_LI: begin
        o_word  = {i_imm[11:0], 5'd0, F3_ADD, i_rd, OPC_OP_IMM};
        o_legal = fits12;
      end
      OP_LW: begin
        o_word  = {i_imm[11:0], i_rs1, F3_W, i_rd, OPC_LOAD};
        o_legal = fits12;
      end
      OP_JALR: begin
        o_word  = {i_imm[11:0], i_rs1, F3_ADD, i_rd, OPC_JALR};
        o_legal = fits12;
      end
      OP_SW: begin
        o_word  = {i_imm[11:5], i_rs2, i_rs1, F3_W, i_imm[4:0], OPC_STORE};
        o_legal = fits12;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        o_word  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, f3, i_imm[4:1], i_imm[11], OPC_BRANCH};
        o_legal = fits13 && !i_imm[0];
      end
      OP_JAL: begin
        o_word  = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OPC_JAL};
        o_legal = fits21 && !i_imm[0];
      end
      OP_LUI: begin
        o_word  = {i_imm[31:12], i_rd, OPC_LUI};
        o_legal = 1'b1;
      end
      OP_AUIPC: begin
        o_word  = {i_imm[31:12], i_rd, OPC_AUIPC};
        o_legal = 1'b1;
      end
      default: begin
        o_word  = '0;
        o_legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/imem_prog_encoder.sv
// Encodes symbolic RV32I requests and writes them to consecutive imem word addresses.
// Latency: accept in cycle N -> write (or o_err pulse) registered in N+1; long LI writes N+1, N+2.
// Backpressure: o_ready low during the second LI word and while full; only i_start/reset refill.
// Ports: i_clk/i_rst_n, i_start restart, i_valid/o_ready request handshake, i_op/i_rd/i_rs1/i_rs2/i_imm
//        fields; o_imem_wren/o_imem_addr/o_imem_data write port; o_err reject pulse; o_full; o_count.
// Macro: LI_EXPAND_EN enables the LI pseudo-op (single ADDI or LUI+ADDI); otherwise LI is rejected.
module imem_prog_encoder
  import imem_prog_encoder_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  op_e                      i_op,
  input  logic [4:0]               i_rd,
  input  logic [4:0]               i_rs1,
  input  logic [4:0]               i_rs2,
  input  logic [31:0]              i_imm,
  output logic                     o_imem_wren,
  output logic [31:0]              o_imem_addr,
  output logic [31:0]              o_imem_data,
  output logic                     o_err,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   li2_q, li2_d;
  logic          wren_q, wren_d;
  logic          err_q, err_d;

  logic [31:0]   pack_word, first_word, second_word, wr_addr;
  logic          pack_legal, req_legal, req_two, last_slot;

  rv32i_field_pack u_pack (
    .i_op    (i_op),
    .i_rd    (i_rd),
    .i_rs1   (i_rs1),
    .i_rs2   (i_rs2),
    .i_imm   (i_imm),
    .o_word  (pack_word),
    .o_legal (pack_legal)
  );

`ifdef LI_EXPAND_EN
  // ADDI sign-extends its 12 bits, so the upper part is pre-biased by imm[11].
  logic [19:0] li_hi;
  assign li_hi       = i_imm[31:12] + {19'd0, i_imm[11]};
  assign second_word = {i_imm[11:0], i_rd, F3_ADD, i_rd, OPC_OP_IMM};
`else
  assign second_word = '0;
`endif

  always_comb begin
    req_legal  = pack_legal;
    req_two    = 1'b0;
    first_word = pack_word;
    if (i_op == OP_LI) begin
`ifdef LI_EXPAND_EN
      if (!pack_legal) begin
        req_legal  = 1'b1;
        req_two    = 1'b1;
        first_word = {li_hi, i_rd, OPC_LUI};
      end
`else
      req_legal  = 1'b0;
`endif
    end
  end

  assign wr_addr   = BASE_ADDR + (32'(count_q) << 2);
  assign last_slot = (count_q == CW'(DEPTH - 1));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    li2_d   = li2_q;
    wren_d  = 1'b0;
    err_d   = 1'b0;
    if (i_start) begin
      // Restart wins over any accept and drops a pending LI second word.
      state_d = S_RUN;
      count_d = '0;
      addr_d  = BASE_ADDR;
    end else begin
      case (state_q)
        S_RUN: begin
          if (i_valid) begin
            // A two-word LI is refused outright rather than split across a full boundary.
            if (!req_legal || (req_two && last_slot)) begin
              err_d = 1'b1;
            end else begin
              wren_d  = 1'b1;
              addr_d  = wr_addr;
              data_d  = first_word;
              count_d = count_q + CW'(1);
              if (req_two) begin
                state_d = S_LI2;
                li2_d   = second_word;
              end else if (last_slot) begin
                state_d = S_FULL;
              end
            end
          end
        end
        S_LI2: begin
          wren_d  = 1'b1;
          addr_d  = wr_addr;
          data_d  = li2_q;
          count_d = count_q + CW'(1);
          state_d = last_slot ? S_FULL : S_RUN;
        end
        default: ;  // S_FULL holds until restart
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_RUN;
      count_q <= '0;
      addr_q  <= BASE_ADDR;
      data_q  <= '0;
      li2_q   <= '0;
      wren_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      li2_q   <= li2_d;
      wren_q  <= wren_d;
      err_q   <= err_d;
    end
  end

  assign o_ready     = (state_q == S_RUN);
  assign o_full      = (state_q == S_FULL);
  assign o_imem_wren = wren_q;
  assign o_imem_addr = addr_q;
  assign o_imem_data = data_q;
  assign o_err       = err_q;
  assign o_count     = count_q;

endmodule

// File: tb/tb_imem_prog_encoder.sv
// Bench for imem_prog_encoder: directed scenarios plus randomized requests against a reference model.
// Latency: checks each request one cycle after acceptance (two for long LI).
// Backpressure: exercises o_ready low in the LI second cycle and while full.
module tb_imem_prog_encoder;
  import imem_prog_encoder_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  op_e         i_op = OP_ADD;
  logic [4:0]  i_rd = '0, i_rs1 = '0, i_rs2 = '0;
  logic [31:0] i_imm = '0;
  logic        o_imem_wren;
  logic [31:0] o_imem_addr, o_imem_data;
  logic        o_err, o_full;
  logic [2:0]  o_count;

  int total = 0;
  int bad = 0;
  int cnt = 0;   // words the model believes are written since reset/start
  int bnd [0:17] = '{-4096, -4097, -2049, -2048, 2047, 2048, 4094, 4095, 4096, 31, 32, 0,
                     1048574, 1048575, 1048576, -1048576, -1048578, -3};

  imem_prog_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm),
    .o_imem_wren(o_imem_wren), .o_imem_addr(o_imem_addr), .o_imem_data(o_imem_data),
    .o_err(o_err), .o_full(o_full), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input op_e op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    i_op = op; i_rd = rd; i_rs1 = rs1; i_rs2 = rs2; i_imm = imm; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic restart;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    cnt = 0;
  endtask

  function automatic int tb_f3(input op_e op);
    case (op)
      OP_SLL, OP_SLLI, OP_BNE:                    return 1;
      OP_SLT, OP_SLTI, OP_LW, OP_SW:              return 2;
      OP_SLTU, OP_SLTIU:                          return 3;
      OP_XOR, OP_XORI, OP_BLT:                    return 4;
      OP_SRL, OP_SRA, OP_SRLI, OP_SRAI, OP_BGE:   return 5;
      OP_OR, OP_ORI, OP_BLTU:                     return 6;
      OP_AND, OP_ANDI, OP_BGEU:                   return 7;
      default:                                    return 0;
    endcase
  endfunction

  // Returns number of words the request produces (0 = rejected); w0/w1 are the words.
  function automatic int model(input op_e op, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] imm,
                               output logic [31:0] w0, output logic [31:0] w1);
    int s, n;
    logic [31:0] rdv, r1, r2, f3, f7;
    int lo;
    logic [31:0] hi;
    s   = $signed(imm);
    rdv = 32'(rd) << 7;
    r1  = 32'(rs1) << 15;
    r2  = 32'(rs2) << 20;
    f3  = 32'(tb_f3(op)) << 12;
    f7  = (op == OP_SUB || op == OP_SRA || op == OP_SRAI) ? 32'h4000_0000 : 32'h0;
    w0 = '0; w1 = '0; n = 0;
    case (op)
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRA, OP_SRL, OP_OR, OP_AND: begin
        w0 = f7 | r2 | r1 | f3 | rdv | 32'h33; n = 1;
      end
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_LW, OP_JALR:
        if (s >= -2048 && s <= 2047) begin
          w0 = ((imm & 32'hFFF) << 20) | r1 | f3 | rdv |
               ((op == OP_LW) ? 32'h03 : (op == OP_JALR) ? 32'h67 : 32'h13);
          n = 1;
        end
      OP_SLLI, OP_SRLI, OP_SRAI:
        if (s >= 0 && s <= 31) begin
          w0 = f7 | (imm << 20) | r1 | f3 | rdv | 32'h13; n = 1;
        end
      OP_SW:
        if (s >= -2048 && s <= 2047) begin
          w0 = (((imm >> 5) & 32'h7F) << 25) | r2 | r1 | f3 | ((imm & 32'h1F) << 7) | 32'h23;
          n = 1;
        end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU:
        if (s >= -4096 && s <= 4094 && (imm & 32'h1) == 0) begin
          w0 = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | r2 | r1 | f3 |
               (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'h63;
          n = 1;
        end
      OP_JAL:
        if (s >= -1048576 && s <= 1048574 && (imm & 32'h1) == 0) begin
          w0 = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
               (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | rdv | 32'h6F;
          n = 1;
        end
      OP_LUI:   begin w0 = (imm & 32'hFFFF_F000) | rdv | 32'h37; n = 1; end
      OP_AUIPC: begin w0 = (imm & 32'hFFFF_F000) | rdv | 32'h17; n = 1; end
      OP_LI: begin
`ifdef LI_EXPAND_EN
        if (s >= -2048 && s <= 2047) begin
          w0 = ((imm & 32'hFFF) << 20) | rdv | 32'h13; n = 1;
        end else begin
          lo = int'(imm & 32'hFFF);
          if (lo >= 2048) lo = lo - 4096;
          hi = imm - 32'(lo);
          w0 = (hi & 32'hFFFF_F000) | rdv | 32'h37;
          w1 = ((imm & 32'hFFF) << 20) | (32'(rd) << 15) | rdv | 32'h13;
          n = 2;
        end
`else
        n = 0;
`endif
      end
      default: n = 0;
    endcase
    return n;
  endfunction

  task automatic test_reset;
    #1;
    total++; if (o_imem_wren !== 1'b0) begin bad++; $display("FAIL rst_wren got=%b exp=0", o_imem_wren); end
    total++; if (o_imem_addr !== BASE) begin bad++; $display("FAIL rst_addr got=%h exp=%h", o_imem_addr, BASE); end
    total++; if (o_imem_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", o_imem_data); end
    total++; if (o_err !== 1'b0 || o_full !== 1'b0) begin bad++; $display("FAIL rst_err_full got=%b%b exp=00", o_err, o_full); end
    total++; if (o_count !== 3'd0 || o_ready !== 1'b1) begin bad++; $display("FAIL rst_count_ready got=%0d/%b exp=0/1", o_count, o_ready); end
    tick();
    i_rst_n = 1'b1;
    tick();
    cnt = 0;
  endtask

  task automatic test_add;
    restart();
    issue(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
    total++; if (o_imem_wren !== 1'b1 || o_imem_addr !== 32'h0) begin bad++; $display("FAIL add_wr got=%b@%h exp=1@0", o_imem_wren, o_imem_addr); end
    total++; if (o_imem_data !== 32'h002081B3) begin bad++; $display("FAIL add_data got=%h exp=002081b3", o_imem_data); end
    total++; if (o_count !== 3'd1) begin bad++; $display("FAIL add_count got=%0d exp=1", o_count); end
    tick();
    total++; if (o_imem_wren !== 1'b0) begin bad++; $display("FAIL add_wren_pulse got=%b exp=0", o_imem_wren); end
  endtask

  task automatic test_back_to_back;
    restart();
    issue(OP_SRAI, 5'd5, 5'd6, 5'd0, 32'd3);
    total++; if (o_imem_data !== 32'h40335293 || o_imem_addr !== 32'h0) begin bad++; $display("FAIL b2b_srai got=%h@%h exp=40335293@0", o_imem_data, o_imem_addr); end
    issue(OP_SW, 5'd0, 5'd1, 5'd2, -32'sd4);
    total++; if (o_imem_data !== 32'hFE20AE23 || o_imem_addr !== 32'h4) begin bad++; $display("FAIL b2b_sw got=%h@%h exp=fe20ae23@4", o_imem_data, o_imem_addr); end
    total++; if (o_imem_wren !== 1'b1 || o_count !== 3'd2) begin bad++; $display("FAIL b2b_count got=%b/%0d exp=1/2", o_imem_wren, o_count); end
  endtask

  task automatic test_err;
    restart();
    issue(OP_ADD, 5'd1, 5'd1, 5'd1, 32'd0);
    issue(OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd3);
    total++; if (o_err !== 1'b1 || o_imem_wren !== 1'b0) begin bad++; $display("FAIL err_beq got=err%b/wren%b exp=1/0", o_err, o_imem_wren); end
    total++; if (o_count !== 3'd1) begin bad++; $display("FAIL err_count got=%0d exp=1", o_count); end
    issue(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd7);
    total++; if (o_err !== 1'b0 || o_imem_wren !== 1'b1) begin bad++; $display("FAIL err_next got=err%b/wren%b exp=0/1", o_err, o_imem_wren); end
    total++; if (o_imem_addr !== 32'h4 || o_imem_data !== 32'h00700093) begin bad++; $display("FAIL err_next_word got=%h@%h exp=00700093@4", o_imem_data, o_imem_addr); end
  endtask

  task automatic test_li;
    restart();
    issue(OP_LI, 5'd1, 5'd0, 5'd0, 32'h12345FFF);
`ifdef LI_EXPAND_EN
    total++; if (o_imem_data !== 32'h123460B7 || o_imem_wren !== 1'b1) begin bad++; $display("FAIL li_lui got=%h/%b exp=123460b7/1", o_imem_data, o_imem_wren); end
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL li_ready got=%b exp=0", o_ready); end
    i_op = OP_ADD; i_valid = 1'b1;   // must be ignored while o_ready is low
    tick();
    i_valid = 1'b0;
    total++; if (o_imem_data !== 32'hFFF08093 || o_imem_addr !== 32'h4) begin bad++; $display("FAIL li_addi got=%h@%h exp=fff08093@4", o_imem_data, o_imem_addr); end
    total++; if (o_ready !== 1'b1 || o_count !== 3'd2) begin bad++; $display("FAIL li_after got=%b/%0d exp=1/2", o_ready, o_count); end
    tick();
    total++; if (o_imem_wren !== 1'b0) begin bad++; $display("FAIL li_ignored got=%b exp=0", o_imem_wren); end
    issue(OP_LI, 5'd1, 5'd0, 5'd0, 32'd5);
    total++; if (o_imem_data !== 32'h00500093 || o_imem_addr !== 32'h8) begin bad++; $display("FAIL li_short got=%h@%h exp=00500093@8", o_imem_data, o_imem_addr); end
`else
    total++; if (o_err !== 1'b1 || o_imem_wren !== 1'b0) begin bad++; $display("FAIL li_off_long got=err%b/wren%b exp=1/0", o_err, o_imem_wren); end
    issue(OP_LI, 5'd1, 5'd0, 5'd0, 32'd5);
    total++; if (o_err !== 1'b1 || o_count !== 3'd0) begin bad++; $display("FAIL li_off_short got=err%b/cnt%0d exp=1/0", o_err, o_count); end
`endif
  endtask

  task automatic test_full;
    restart();
    for (int k = 0; k < DEPTH; k++) begin
      issue(OP_ADDI, 5'(k + 1), 5'd0, 5'd0, 32'(k));
      total++; if (o_imem_addr !== 32'(4 * k) || o_imem_wren !== 1'b1) begin bad++; $display("FAIL full_wr%0d got=%b@%h exp=1@%h", k, o_imem_wren, o_imem_addr, 32'(4 * k)); end
    end
    total++; if (o_full !== 1'b1 || o_ready !== 1'b0) begin bad++; $display("FAIL full_flags got=%b/%b exp=1/0", o_full, o_ready); end
    issue(OP_ADD, 5'd1, 5'd2, 5'd3, 32'd0);
    total++; if (o_imem_wren !== 1'b0 || o_err !== 1'b0 || o_count !== 3'd4) begin bad++; $display("FAIL full_ignore got=%b/%b/%0d exp=0/0/4", o_imem_wren, o_err, o_count); end
    restart();
    total++; if (o_imem_addr !== BASE || o_count !== 3'd0 || o_ready !== 1'b1 || o_full !== 1'b0) begin bad++; $display("FAIL full_restart got=%h/%0d/%b/%b exp=0/0/1/0", o_imem_addr, o_count, o_ready, o_full); end
  endtask

  task automatic test_li_one_slot;
    restart();
    for (int k = 0; k < DEPTH - 1; k++) issue(OP_XOR, 5'd1, 5'd2, 5'd3, 32'd0);
    issue(OP_LI, 5'd2, 5'd0, 5'd0, 32'h12345678);
    total++; if (o_err !== 1'b1 || o_imem_wren !== 1'b0 || o_count !== 3'd3) begin bad++; $display("FAIL li_slot got=%b/%b/%0d exp=1/0/3", o_err, o_imem_wren, o_count); end
    issue(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
    total++; if (o_imem_addr !== 32'hC || o_imem_data !== 32'h002081B3 || o_full !== 1'b1) begin bad++; $display("FAIL li_slot_last got=%h@%h full=%b exp=002081b3@c full=1", o_imem_data, o_imem_addr, o_full); end
  endtask

  task automatic test_reset_mid_li;
    restart();
    issue(OP_LI, 5'd4, 5'd0, 5'd0, 32'hABCDE123);
    i_rst_n = 1'b0;
    #1;
    total++; if (o_imem_wren !== 1'b0 || o_imem_addr !== BASE || o_imem_data !== 32'h0) begin bad++; $display("FAIL midli_out got=%b/%h/%h exp=0/0/0", o_imem_wren, o_imem_addr, o_imem_data); end
    total++; if (o_err !== 1'b0 || o_count !== 3'd0 || o_ready !== 1'b1 || o_full !== 1'b0) begin bad++; $display("FAIL midli_flags got=%b/%0d/%b/%b exp=0/0/1/0", o_err, o_count, o_ready, o_full); end
    tick();
    i_rst_n = 1'b1;
    tick();
    total++; if (o_imem_wren !== 1'b0 || o_count !== 3'd0) begin bad++; $display("FAIL midli_nowrite got=%b/%0d exp=0/0", o_imem_wren, o_count); end
    cnt = 0;
  endtask

  task automatic test_random;
    op_e         op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, w0, w1;
    int          n;
    bit          rej;
    restart();
    for (int k = 0; k < 300; k++) begin
      op  = op_e'(5'($urandom_range(0, 31)));
      rd  = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      case ($urandom_range(0, 3))
        0:       imm = 32'(int'($urandom_range(0, 64)) - 32);
        1:       imm = $urandom;
        2:       imm = 32'(bnd[$urandom_range(0, 17)]);
        default: imm = 32'(int'($urandom_range(0, 8191)) - 4096);
      endcase
      n = model(op, rd, rs1, rs2, imm, w0, w1);
      if (cnt == DEPTH) begin
        issue(op, rd, rs1, rs2, imm);
        total++; if (o_imem_wren !== 1'b0 || o_err !== 1'b0 || o_full !== 1'b1) begin bad++; $display("FAIL rnd_full %s got=%b/%b/%b exp=0/0/1", op.name(), o_imem_wren, o_err, o_full); end
        restart();
        total++; if (o_count !== 3'd0 || o_ready !== 1'b1) begin bad++; $display("FAIL rnd_restart got=%0d/%b exp=0/1", o_count, o_ready); end
      end else begin
        rej = (n == 0) || (n == 2 && cnt == DEPTH - 1);
        issue(op, rd, rs1, rs2, imm);
        total++; if (o_err !== rej || o_imem_wren !== !rej) begin bad++; $display("FAIL rnd_accept %s imm=%h got=err%b/wren%b exp=%b/%b", op.name(), imm, o_err, o_imem_wren, rej, !rej); end
        if (!rej) begin
          total++; if (o_imem_data !== w0 || o_imem_addr !== BASE + 32'(4 * cnt)) begin bad++; $display("FAIL rnd_word %s imm=%h got=%h@%h exp=%h@%h", op.name(), imm, o_imem_data, o_imem_addr, w0, BASE + 32'(4 * cnt)); end
          cnt++;
          if (n == 2) begin
            total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL rnd_li_ready got=%b exp=0", o_ready); end
            tick();
            total++; if (o_imem_data !== w1 || o_imem_addr !== BASE + 32'(4 * cnt)) begin bad++; $display("FAIL rnd_li2 imm=%h got=%h@%h exp=%h@%h", imm, o_imem_data, o_imem_addr, w1, BASE + 32'(4 * cnt)); end
            cnt++;
          end
        end
        total++; if (o_count !== 3'(cnt)) begin bad++; $display("FAIL rnd_count got=%0d exp=%0d", o_count, cnt); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_err();
    test_li();
    test_full();
    test_li_one_slot();
    test_reset_mid_li();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
